// File: rtl/armleocpu_prefetch_if.sv
// Fetch front-end bundle: instruction-cache port, fetch-to-execute queue head,
// execute/debug control back to fetch.
interface armleocpu_prefetch_if;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [3:0]  c_response;
  logic        c_reset_done;
  logic [31:0] c_load_data;

  logic        f2e_valid;
  logic        f2e_ready;
  logic [31:0] f2e_instr;
  logic [31:0] f2e_pc;
  logic        f2e_fault;
  logic [31:0] f2e_cause;

  logic        e2f_redirect;
  logic        e2f_flush;
  logic [31:0] e2f_target;

  logic        dbg_halt;
  logic        dbg_halted;
  logic        instret_incr;

  modport master (
    output c_cmd, c_address,
    input  c_response, c_reset_done, c_load_data,
    output f2e_valid, f2e_instr, f2e_pc, f2e_fault, f2e_cause,
    input  f2e_ready,
    input  e2f_redirect, e2f_flush, e2f_target,
    input  dbg_halt,
    output dbg_halted, instret_incr
  );

  modport slave (
    input  c_cmd, c_address,
    output c_response, c_reset_done, c_load_data,
    input  f2e_valid, f2e_instr, f2e_pc, f2e_fault, f2e_cause,
    output f2e_ready,
    output e2f_redirect, e2f_flush, e2f_target,
    output dbg_halt,
    input  dbg_halted, instret_incr
  );
endinterface

// File: rtl/armleocpu_prefetch.sv
// Instruction prefetch: sequential PC prediction, one outstanding cache request,
// DEPTH-entry queue of {instr, pc, fault, cause} feeding execute.
//
// state       | meaning
// FETCH       | normal sequential fetching into the queue
// FLUSH_WAIT  | flush requested, draining the in-flight (dropped) request
// FLUSH_CMD   | FLUSH_ALL issued to the cache, waiting for DONE
module armleocpu_prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_2000,
  parameter int          DEPTH        = 4,
  parameter int          PTR_W        = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  armleocpu_prefetch_if.master bus
);

  localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
  localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd4;
  localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd5;

  localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_ADDRESS_MISSALIGNED = 32'd0;
  localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_ACCESS_FAULT        = 32'd1;
  localparam logic [31:0] EXCEPTION_CODE_INSTRUCTION_PAGE_FAULT          = 32'd12;
  localparam logic [31:0] INSTRUCTION_NOP                                = 32'h0000_0013;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    STATE_FETCH,
    STATE_FLUSH_WAIT,
    STATE_FLUSH_CMD
  } state_t;

  state_t           r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic             r_inflight;
  logic             r_drop;
  logic             r_stopped;
  logic             r_flush_issued;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic [31:0] r_q_instr [DEPTH];
  logic [31:0] r_q_pc    [DEPTH];
  logic        r_q_fault [DEPTH];
  logic [31:0] r_q_cause [DEPTH];

  logic           w_terminal;
  logic           w_resp_fault;
  logic [31:0]    w_resp_cause;
  logic           w_resp_done;
  logic           w_kill;
  logic [PTR_W:0] w_occupancy;
  logic           w_issue;
  logic           w_flush_cmd;
  logic           w_push;
  logic           w_pop;
  logic           w_head_valid;
  logic           w_head_fault;

  always_comb begin
    w_terminal   = 1'b0;
    w_resp_fault = 1'b0;
    w_resp_cause = 32'd0;
    case (bus.c_response)
      CACHE_RESPONSE_DONE: w_terminal = 1'b1;
      CACHE_RESPONSE_ACCESSFAULT: begin
        w_terminal   = 1'b1;
        w_resp_fault = 1'b1;
        w_resp_cause = EXCEPTION_CODE_INSTRUCTION_ACCESS_FAULT;
      end
      CACHE_RESPONSE_MISSALIGNED: begin
        w_terminal   = 1'b1;
        w_resp_fault = 1'b1;
        w_resp_cause = EXCEPTION_CODE_INSTRUCTION_ADDRESS_MISSALIGNED;
      end
      CACHE_RESPONSE_PAGEFAULT: begin
        w_terminal   = 1'b1;
        w_resp_fault = 1'b1;
        w_resp_cause = EXCEPTION_CODE_INSTRUCTION_PAGE_FAULT;
      end
      default: ;
    endcase
  end

  assign w_resp_done = r_inflight && w_terminal;
  assign w_kill      = (r_state == STATE_FETCH) && (bus.e2f_redirect || bus.e2f_flush);
  // In-flight slot is reserved up front so a response can always be pushed.
  assign w_occupancy = r_count + {{PTR_W{1'b0}}, r_inflight};

  assign w_issue = rst_n && (r_state == STATE_FETCH) && bus.c_reset_done && !r_inflight
                && !r_stopped && !bus.dbg_halt && !bus.e2f_redirect && !bus.e2f_flush
                && (w_occupancy < DEPTH_C);
  assign w_flush_cmd = rst_n && (r_state == STATE_FLUSH_CMD) && !r_flush_issued
                    && bus.c_reset_done;

  assign w_push       = w_resp_done && !r_drop && (r_state == STATE_FETCH) && !w_kill;
  assign w_head_valid = (r_count != '0);
  assign w_head_fault = r_q_fault[r_rptr];
  assign w_pop        = rst_n && w_head_valid && bus.f2e_ready && !w_kill;

  assign bus.c_cmd     = w_issue     ? CACHE_CMD_EXECUTE   :
                         w_flush_cmd ? CACHE_CMD_FLUSH_ALL : CACHE_CMD_NONE;
  assign bus.c_address = r_fetch_pc;

  assign bus.f2e_valid    = w_head_valid;
  assign bus.f2e_pc       = r_q_pc[r_rptr];
  assign bus.f2e_fault    = w_head_valid && w_head_fault;
  assign bus.f2e_cause    = (w_head_valid && w_head_fault) ? r_q_cause[r_rptr] : 32'd0;
  assign bus.f2e_instr    = (w_head_valid && !w_head_fault) ? r_q_instr[r_rptr] : INSTRUCTION_NOP;
  assign bus.instret_incr = w_pop && !w_head_fault;
  assign bus.dbg_halted   = rst_n && bus.dbg_halt && !r_inflight && (r_state == STATE_FETCH);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= bus.c_load_data;
      r_q_pc[r_wptr]    <= r_req_pc;
      r_q_fault[r_wptr] <= w_resp_fault;
      r_q_cause[r_wptr] <= w_resp_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= STATE_FETCH;
      r_fetch_pc     <= RESET_VECTOR;
      r_req_pc       <= RESET_VECTOR;
      r_inflight     <= 1'b0;
      r_drop         <= 1'b0;
      r_stopped      <= 1'b0;
      r_flush_issued <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
    end else begin
      if (w_issue) begin
        r_inflight <= 1'b1;
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_resp_done) begin
        r_inflight <= 1'b0;
        r_drop     <= 1'b0;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        if (w_resp_fault)
          r_stopped <= 1'b1;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;

      case (r_state)
        STATE_FETCH: begin
          if (bus.e2f_flush || bus.e2f_redirect) begin
            r_fetch_pc <= bus.e2f_target;
            r_stopped  <= 1'b0;
            r_drop     <= r_inflight && !w_resp_done;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            if (bus.e2f_flush) begin
              r_flush_issued <= 1'b0;
              r_state <= (r_inflight && !w_resp_done) ? STATE_FLUSH_WAIT : STATE_FLUSH_CMD;
            end
          end
        end
        STATE_FLUSH_WAIT: begin
          if (bus.e2f_flush || bus.e2f_redirect)
            r_fetch_pc <= bus.e2f_target;
          if (w_resp_done)
            r_state <= STATE_FLUSH_CMD;
        end
        STATE_FLUSH_CMD: begin
          if (bus.e2f_flush || bus.e2f_redirect)
            r_fetch_pc <= bus.e2f_target;
          if (w_flush_cmd)
            r_flush_issued <= 1'b1;
          else if (r_flush_issued && (bus.c_response == CACHE_RESPONSE_DONE))
            r_state <= STATE_FETCH;
        end
        default: r_state <= STATE_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_prefetch.sv
// Directed bench for armleocpu_prefetch: behavioural cache with programmable
// latency/faults, scoreboard of expected queue pops checked on each handshake.
module tb_armleocpu_prefetch;

  localparam logic [3:0]  CMD_NONE      = 4'd0;
  localparam logic [3:0]  CMD_EXECUTE   = 4'd1;
  localparam logic [3:0]  CMD_FLUSH_ALL = 4'd4;
  localparam logic [3:0]  RSP_IDLE      = 4'd0;
  localparam logic [3:0]  RSP_WAIT      = 4'd1;
  localparam logic [3:0]  RSP_DONE      = 4'd2;
  localparam logic [3:0]  RSP_PAGEFAULT = 4'd5;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] cause;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  armleocpu_prefetch_if bus();

  armleocpu_prefetch #(.RESET_VECTOR(32'h0000_2000), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  function automatic logic [31:0] idata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cache model: terminal response `lat` cycles after a command.
  int          lat = 1;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;
  logic [3:0]  fault_resp = RSP_PAGEFAULT;
  int          cnt = 0;
  int          issue_cnt = 0;
  int          flush_cnt = 0;
  int          proto_err = 0;
  logic [3:0]  pend_resp = RSP_IDLE;
  logic [31:0] pend_data = 32'd0;
  logic [3:0]  w_resp_now;
  logic [31:0] w_data_now;

  assign w_resp_now = (bus.c_cmd == CMD_FLUSH_ALL) ? RSP_DONE :
                      (bus.c_address == fault_addr) ? fault_resp : RSP_DONE;
  assign w_data_now = (bus.c_cmd == CMD_FLUSH_ALL) ? 32'd0 : idata(bus.c_address);

  always @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= 0;
      bus.c_response <= RSP_IDLE;
    end else if (bus.c_cmd != CMD_NONE) begin
      if (cnt != 0) proto_err <= proto_err + 1;
      if (bus.c_cmd == CMD_EXECUTE) issue_cnt <= issue_cnt + 1;
      else flush_cnt <= flush_cnt + 1;
      pend_resp <= w_resp_now;
      pend_data <= w_data_now;
      if (lat <= 1) begin
        cnt             <= 0;
        bus.c_response  <= w_resp_now;
        bus.c_load_data <= w_data_now;
      end else begin
        cnt            <= lat - 1;
        bus.c_response <= RSP_WAIT;
      end
    end else if (cnt > 1) begin
      cnt            <= cnt - 1;
      bus.c_response <= RSP_WAIT;
    end else if (cnt == 1) begin
      cnt             <= 0;
      bus.c_response  <= pend_resp;
      bus.c_load_data <= pend_data;
    end else begin
      bus.c_response <= RSP_IDLE;
    end
  end

  // Scoreboard: every accepted head is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.f2e_valid && bus.f2e_ready && !bus.e2f_redirect && !bus.e2f_flush
        && sb.size() != 0) begin
      chk("pop_pc",      bus.f2e_pc,       sb[0].pc);
      chk("pop_instr",   bus.f2e_instr,    sb[0].instr);
      chk("pop_fault",   bus.f2e_fault,    sb[0].fault);
      chk("pop_cause",   bus.f2e_cause,    sb[0].cause);
      chk("pop_instret", bus.instret_incr, !sb[0].fault);
      sb.delete(0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ok(input logic [31:0] pc);
    sb.push_back('{pc: pc, instr: idata(pc), fault: 1'b0, cause: 32'd0});
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    bus.f2e_ready = 1'b1;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    bus.f2e_ready = 1'b0;
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_cmd(input string tag, input logic [3:0] cmd, input int max);
    int n = 0;
    @(negedge clk);
    while (bus.c_cmd !== cmd && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.c_cmd, cmd);
  endtask

  task automatic pulse(input logic redirect, input logic [31:0] target);
    bus.e2f_target   = target;
    bus.e2f_redirect = redirect;
    bus.e2f_flush    = !redirect;
    step();
    bus.e2f_redirect = 1'b0;
    bus.e2f_flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int n;
    bus.c_reset_done = 1'b1;
    bus.f2e_ready    = 1'b0;
    bus.e2f_redirect = 1'b0;
    bus.e2f_flush    = 1'b0;
    bus.e2f_target   = 32'd0;
    bus.dbg_halt     = 1'b0;

    repeat (3) step();
    chk("rst_cmd",     bus.c_cmd,        CMD_NONE);
    chk("rst_valid",   bus.f2e_valid,    1'b0);
    chk("rst_fault",   bus.f2e_fault,    1'b0);
    chk("rst_cause",   bus.f2e_cause,    32'd0);
    chk("rst_instret", bus.instret_incr, 1'b0);
    chk("rst_halted",  bus.dbg_halted,   1'b0);

    // Streaming with execute always ready
    expect_ok(32'h2000); expect_ok(32'h2004); expect_ok(32'h2008);
    rst_n = 1'b1;
    drain("t1_drain", 60);

    // Backpressure: exactly DEPTH issues, then resume at 0x2010
    do_reset();
    base = issue_cnt;
    repeat (20) step();
    chk("t2_issues", issue_cnt - base, 4);
    chk("t2_cmd_idle", bus.c_cmd, CMD_NONE);
    chk("t2_head_pc", bus.f2e_pc, 32'h2000);
    for (int i = 0; i < 5; i++) expect_ok(32'h2000 + 32'(i * 4));
    drain("t2_drain", 60);

    // Redirect while 0x200C is waiting in the cache
    lat = 4;
    do_reset();
    n = 0;
    @(negedge clk);
    while (!(bus.c_cmd == CMD_EXECUTE && bus.c_address == 32'h200C) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_issue_200c", bus.c_address, 32'h200C);
    step();
    chk("t3_wait", bus.c_response, RSP_WAIT);
    pulse(1'b1, 32'h8000);
    chk("t3_queue_empty", bus.f2e_valid, 1'b0);
    expect_ok(32'h8000); expect_ok(32'h8004);
    drain("t3_drain", 80);

    // Page fault stops fetching until redirect
    lat = 1;
    fault_addr = 32'h3000;
    pulse(1'b1, 32'h3000);
    n = 0;
    @(negedge clk);
    while (!bus.f2e_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid", bus.f2e_valid, 1'b1);
    chk("t4_pc",    bus.f2e_pc,    32'h3000);
    chk("t4_fault", bus.f2e_fault, 1'b1);
    chk("t4_cause", bus.f2e_cause, 32'd12);
    chk("t4_instr", bus.f2e_instr, NOP);
    base = issue_cnt;
    repeat (10) step();
    chk("t4_no_issue", issue_cnt - base, 0);
    chk("t4_cmd_idle", bus.c_cmd, CMD_NONE);
    sb.push_back('{pc: 32'h3000, instr: NOP, fault: 1'b1, cause: 32'd12});
    drain("t4_fault_drain", 20);
    fault_addr = 32'hFFFF_FFFF;
    pulse(1'b1, 32'h100);
    expect_ok(32'h100); expect_ok(32'h104);
    drain("t4_drain", 60);

    // Flush during an in-flight request
    lat = 3;
    pulse(1'b1, 32'h5000);
    wait_cmd("t5_exec", CMD_EXECUTE, 30);
    chk("t5_exec_addr", bus.c_address, 32'h5000);
    step();
    base = flush_cnt;
    pulse(1'b0, 32'h4004);
    chk("t5_queue_empty", bus.f2e_valid, 1'b0);
    wait_cmd("t5_flush_cmd", CMD_FLUSH_ALL, 20);
    chk("t5_drained", cnt, 0);
    chk("t5_resp_idle", bus.c_response, RSP_IDLE);
    wait_cmd("t5_refetch", CMD_EXECUTE, 20);
    chk("t5_refetch_addr", bus.c_address, 32'h4004);
    chk("t5_flush_count", flush_cnt - base, 1);
    expect_ok(32'h4004);
    drain("t5_drain", 40);

    // Debug halt during WAIT, plus address wrap
    pulse(1'b1, 32'hFFFF_FFFC);
    wait_cmd("t6_exec", CMD_EXECUTE, 30);
    chk("t6_exec_addr", bus.c_address, 32'hFFFF_FFFC);
    step();
    bus.dbg_halt = 1'b1;
    chk("t6_halted_wait", bus.dbg_halted, 1'b0);
    n = 0;
    @(negedge clk);
    while (bus.c_response != RSP_DONE && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_done", bus.c_response, RSP_DONE);
    chk("t6_halted_done", bus.dbg_halted, 1'b0);
    step();
    chk("t6_halted", bus.dbg_halted, 1'b1);
    base = issue_cnt;
    repeat (5) step();
    chk("t6_no_issue", issue_cnt - base, 0);
    chk("t6_still_halted", bus.dbg_halted, 1'b1);
    bus.dbg_halt = 1'b0;
    wait_cmd("t6_resume", CMD_EXECUTE, 20);
    chk("t6_wrap_addr", bus.c_address, 32'h0);
    expect_ok(32'hFFFF_FFFC); expect_ok(32'h0);
    drain("t6_drain", 40);

    chk("proto_overlap", proto_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/armleocpu_prefetch.md
Name: armleocpu_prefetch

Overview:
Parametrised next-generation instruction fetch front end. It decouples cache latency from execute with a DEPTH-entry prefetch queue and sequential PC prediction. Each entry carries instruction, PC and fetch-fault info. It sits between the instruction cache port and execute, and takes redirect, flush and debug-halt commands from execute/debug.

Parameters:
RESET_VECTOR, 32'h0000_2000, first fetch address after reset.
DEPTH, 4, queue entries; power of two, 2..16.
PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
c_cmd  out  4  cache command: CACHE_CMD_NONE / CACHE_CMD_EXECUTE / CACHE_CMD_FLUSH_ALL
c_address  out  32  fetch address; valid while c_cmd==EXECUTE
c_response  in  4  CACHE_RESPONSE_IDLE/WAIT/DONE/ACCESSFAULT/MISSALIGNED/PAGEFAULT
c_reset_done  in  1  cache ready; no command issued while 0
c_load_data  in  32  instruction; valid with DONE
f2e_valid  out  1  queue head valid
f2e_ready  in  1  execute accepts head
f2e_instr  out  32  head instruction; INSTRUCTION_NOP when error or !f2e_valid
f2e_pc  out  32  head PC
f2e_fault  out  1  head is a fetch fault
f2e_cause  out  32  EXCEPTION_CODE_INSTRUCTION_{ACCESS_FAULT,ADDRESS_MISSALIGNED,PAGE_FAULT}; 0 if !fault
e2f_redirect  in  1  one-cycle pulse: discard queue, refetch from e2f_target
e2f_flush  in  1  one-cycle pulse: cache FLUSH_ALL, then refetch from e2f_target
e2f_target  in  32  redirect/flush target
dbg_halt  in  1  level: stop issuing fetches
dbg_halted  out  1  dbg_halt && no request in flight && not flushing
instret_incr  out  1  pulse on each f2e_valid && f2e_ready && !f2e_fault

Behaviour:
- Reset (rst_n=0 at clk edge): fetch_pc=RESET_VECTOR; queue empty; inflight=0; drop=0; stopped=0; state=FETCH. Outputs: c_cmd=NONE, f2e_valid=0, f2e_fault=0, f2e_cause=0, instret_incr=0, dbg_halted=0. A reset mid-request discards the response.
- States: FETCH, FLUSH_WAIT (draining in-flight request), FLUSH_CMD (FLUSH_ALL issued, awaiting DONE).
- At most one request outstanding. In FETCH, c_cmd=EXECUTE for one cycle, c_address=fetch_pc, when all hold: c_reset_done, !inflight, !stopped, !dbg_halt, no redirect/flush this cycle, count<DEPTH. Same cycle sets inflight=1 and fetch_pc+=4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
- Request PC is held in req_pc. A terminal response (DONE or fault) clears inflight. If drop=0, push {c_load_data, req_pc, fault, cause}; if drop=1, discard and clear drop. WAIT/IDLE: no action.
- Fault push sets stopped=1: no further issue until redirect/flush. Best-case throughput: one instruction per 2 cycles with a 1-cycle cache.
- Queue: push and pop in the same cycle are legal, including at full (pop frees the slot). The issue condition counts occupancy including the in-flight slot (count+inflight<DEPTH), so push never overflows. Head outputs are combinational from the read pointer.
- Redirect (FETCH): next cycle queue empty, fetch_pc=e2f_target, stopped=0, drop=inflight. Same-cycle push and pop are ignored, and instret_incr=0 that cycle. A new request may issue in the cycle after the drop clears.
- Flush: clear queue, stopped=0, fetch_pc=e2f_target, drop=inflight. Go to FLUSH_WAIT if inflight, else FLUSH_CMD. FLUSH_CMD drives FLUSH_ALL for one cycle, then waits for DONE, then returns to FETCH.
- Flush has priority over redirect if both are asserted. Redirect/flush in FLUSH_* states updates fetch_pc only.
- c_reset_done=0: no command issued; queue contents kept.
- Misaligned targets are not checked here; the cache returns MISSALIGNED, which is queued as a fault.

Test Plan:
- Reset, 1-cycle cache, f2e_ready=1 -> PCs 0x2000, 0x2004, 0x2008 delivered in order; instret_incr pulses once each.
- f2e_ready=0, DEPTH=4 -> exactly 4 EXECUTE issues, then c_cmd=NONE. Raise ready -> 4 pops, fetching resumes at 0x2010.
- Redirect to 0x8000 while a request for 0x200C is in WAIT -> 0x200C response discarded; next f2e_pc=0x8000; queue empty the cycle after the pulse.
- Cache returns PAGEFAULT at 0x3000 -> f2e_fault=1, cause=12, f2e_instr=NOP, no further issue until redirect to 0x100 restarts fetch.
- Flush with target 0x4004 during an in-flight request -> FLUSH_WAIT, then FLUSH_ALL, then DONE, then first fetch at 0x4004.
- dbg_halt during WAIT -> dbg_halted rises the cycle after DONE; release -> fetch continues at the next sequential PC. Start at 0xFFFF_FFFC -> next PC 0x0.
